// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp codes,
// FSM state codes, mux selects and the bundled control-word struct.
package mips_pkg;

  localparam int OP_BITS    = 6;
  localparam int STATE_BITS = 4;

  localparam logic [OP_BITS-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_BITS-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_BITS-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_BITS-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_BITS-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_BITS-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [STATE_BITS-1:0] S_FETCH  = 4'd0;
  localparam logic [STATE_BITS-1:0] S_DECODE = 4'd1;
  localparam logic [STATE_BITS-1:0] S_MEMADR = 4'd2;
  localparam logic [STATE_BITS-1:0] S_MEMRD  = 4'd3;
  localparam logic [STATE_BITS-1:0] S_MEMWB  = 4'd4;
  localparam logic [STATE_BITS-1:0] S_MEMWR  = 4'd5;
  localparam logic [STATE_BITS-1:0] S_EXEC   = 4'd6;
  localparam logic [STATE_BITS-1:0] S_ALUWB  = 4'd7;
  localparam logic [STATE_BITS-1:0] S_BRANCH = 4'd8;
  localparam logic [STATE_BITS-1:0] S_ADDIEX = 4'd9;
  localparam logic [STATE_BITS-1:0] S_ADDIWB = 4'd10;
  localparam logic [STATE_BITS-1:0] S_JUMP   = 4'd11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [OP_BITS-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. RetireCount exists only when
// MIPS_MC_PERF_EN is defined.
interface mips_multicycle_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
);
  // Memory handshake: MemReq (and MemWrite) stay high every cycle until the
  // cycle in which MemReady=1; that cycle completes the access.
  logic [OP_W-1:0]    Op;
  logic               MemReady;
  logic               MemReq;
  logic               MemWrite;
  logic               IRWrite;
  logic               PCWrite;
  logic               Branch;
  logic               IorD;
  logic               RegWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSrc;
  logic               IllegalOp;
  logic [STATE_W-1:0] State;
`ifdef MIPS_MC_PERF_EN
  logic [31:0]        RetireCount;
`endif

  modport master (
    input  Op, MemReady,
    output MemReq, MemWrite, IRWrite, PCWrite, Branch, IorD, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp, State
`ifdef MIPS_MC_PERF_EN
    , output RetireCount
`endif
  );

  modport slave (
    output Op, MemReady,
    input  MemReq, MemWrite, IRWrite, PCWrite, Branch, IorD, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp, State
`ifdef MIPS_MC_PERF_EN
    , input RetireCount
`endif
  );
endinterface

// File: rtl/mips_mc_output_decode.sv
// Pure state decode of the datapath control word; FETCH qualifies its
// IR/PC loads with MemReady so they fire only when the fetch completes.
module mips_mc_output_decode
  import mips_pkg::*;
(
  input  logic [STATE_BITS-1:0] state_i,
  input  logic                  mem_ready_i,
  output ctrl_t                 ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMMSH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch    = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS: state register, next-state logic and
// reset gating of strobes. Define MIPS_MC_PERF_EN to add RetireCount.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  mips_multicycle_ctrl_if.master bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic               illegal;
  logic               retire;
  ctrl_t              dec;

  assign op        = bus.Op;
  assign mem_ready = bus.MemReady;

  mips_mc_output_decode u_dec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (dec)
  );

  assign illegal = (state_q == S_DECODE) && !is_legal_op(op);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Last step of every legal instruction; illegal-op returns are excluded.
  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                  (state_q == S_BRANCH) || (state_q == S_ADDIWB) ||
                  (state_q == S_JUMP) || ((state_q == S_MEMWR) && mem_ready);

`ifdef MIPS_MC_PERF_EN
  logic [31:0] retire_q;

  always_ff @(posedge CLK) begin
    if (RST)         retire_q <= '0;
    else if (retire) retire_q <= retire_q + 32'd1;
  end

  assign bus.RetireCount = retire_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // Strobes are forced low in reset so an abandoned instruction writes nothing.
  assign bus.MemReq    = dec.mem_req   & ~RST;
  assign bus.MemWrite  = dec.mem_write & ~RST;
  assign bus.IRWrite   = dec.ir_write  & ~RST;
  assign bus.PCWrite   = dec.pc_write  & ~RST;
  assign bus.Branch    = dec.branch    & ~RST;
  assign bus.RegWrite  = dec.reg_write & ~RST;
  assign bus.IllegalOp = illegal       & ~RST;
  assign bus.IorD      = dec.iord;
  assign bus.RegDst    = dec.reg_dst;
  assign bus.MemtoReg  = dec.mem_to_reg;
  assign bus.ALUSrcA   = dec.alu_src_a;
  assign bus.ALUSrcB   = dec.alu_src_b;
  assign bus.ALUOp     = dec.alu_op;
  assign bus.PCSrc     = dec.pc_src;
  assign bus.State     = state_q;

endmodule
